mx_block_normalizer: RTL and testbench
======================================

# mx_block_normalizer

Consumer-side partner of the OR-reduction tree in the MX quantisation path. The block buffers each block of signed integer elements while the tree computes the OR of their magnitudes. It then pairs each OR result with the oldest buffered block and derives a shared exponent from the OR's leading one. Finally it arithmetic-right-shifts every element to OUT_WIDTH bits and emits the block and its exponent through a valid/ready register stage.

## Interface
- IN_SIZE, 16, elements per block (≥1)
- IN_WIDTH, 32, signed element width; also the or_in width
- OUT_WIDTH, 8, signed output element width (2 ≤ OUT_WIDTH ≤ IN_WIDTH)
- DEPTH, 4, block buffer depth in blocks (≥2)
- EXP_WIDTH, $clog2(IN_WIDTH), derived, exponent width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  IN_WIDTH × [IN_SIZE]  signed block elements
- data_in_valid / data_in_ready  in / out  1  block push handshake
- or_in  in  IN_WIDTH  OR of element magnitudes for the oldest unpaired block
- or_in_valid / or_in_ready  in / out  1  OR-result handshake
- data_out  out  OUT_WIDTH × [IN_SIZE]  normalised signed elements
- exp_out  out  EXP_WIDTH  shared exponent (right-shift amount)
- data_out_valid / data_out_ready  out / in  1  output handshake

## Operation
- Buffer: a circular FIFO of DEPTH blocks with read pointer, write pointer and count.
  - data_in_ready = (count < DEPTH). There is no pass-through when full.
  - A push occurs on data_in_valid && data_in_ready.
- Pairing: or_in belongs to the block at the FIFO head, in strict order.
  - or_in_ready = (count > 0) && (!data_out_valid || data_out_ready).
  - An or_in handshake pops the head block and loads the output stage in the same edge.
- Exponent rules:
  - lead = index of the highest set bit of or_in.
  - shift = max(0, lead + 2 − OUT_WIDTH).
  - When or_in == 0, shift = 0.
- Element rules:
  - out[i] = low OUT_WIDTH bits of (data[i] >>> shift), an arithmetic shift that truncates toward −∞.
  - exp_out = shift.
- No saturation logic. The block relies on or_in ≥ |data[i]|. Results are undefined if or_in is inconsistent with the block.
- Simultaneous push and pop in one cycle is legal. Count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Output register:
  - Holds data_out, exp_out and data_out_valid stable while data_out_valid && !data_out_ready.
  - data_out_valid falls after a consuming handshake unless a new or_in handshake reloads it on the same edge.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - count = 0 and both pointers = 0, so data_in_ready = 1 and or_in_ready = 0;
  - data_out_valid = 0, data_out = 0, exp_out = 0.
- A push is visible to or_in_ready on the next cycle, because count is registered. An or_in presented earlier waits with ready low.
- Latency: data_out_valid rises on the cycle after the or_in handshake.
- Throughput: one block per cycle under continuous valid/ready.
- data_in_ready falls on the cycle after the push that makes count = DEPTH. It rises on the cycle after the next pop.
- Reset mid-operation discards all buffered blocks and any pending output beat.
- There is no combinational path from data_out_ready to data_in_ready. There is a combinational path from data_out_ready to or_in_ready.

## Test plan
All scenarios use IN_SIZE=4, IN_WIDTH=16, OUT_WIDTH=8, DEPTH=4.
- Push {100, −50, 3, 0}, then or_in = 0x0077 → data_out = {100, −50, 3, 0}, exp_out = 0, one cycle after the or_in handshake.
- Push {1000, −1000, 12, −1}, then or_in = 0x03ED → lead 9, data_out = {125, −125, 1, −1}, exp_out = 3.
- Push {0, 0, 0, 0}, then or_in = 0 → data_out all 0, exp_out = 0.
- Push 4 blocks with no or_in → data_in_ready = 0 and a 5th block is held. One or_in handshake → data_in_ready = 1 on the next cycle. The 5th push is accepted and output order matches push order.
- Present or_in with the FIFO empty → or_in_ready = 0 until the cycle after the first push.
- Hold data_out_ready = 0 with two paired blocks pending → data_out stable and or_in_ready = 0. Release data_out_ready → one beat per cycle, in order.
- Assert rst with 3 blocks buffered and a valid output → data_out_valid = 0, data_in_ready = 1, or_in_ready = 0 immediately. After release, a new block plus or_in produces only the new result.

Source files
------------

// File: rtl/mx_block_normalizer.sv
// rtl/mx_block_normalizer.sv - MX block normaliser: block FIFO, shared exponent, shift and output register
//
// Buffers blocks of signed elements until the matching OR-of-magnitudes result
// arrives. The shared exponent is taken from that result's leading one. Every
// element is then arithmetically shifted right to OUT_WIDTH bits, and the
// normalised block is presented through a valid/ready output register.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   data_in[IN_SIZE]                  signed block elements (IN_WIDTH each)
//   data_in_valid / data_in_ready     block push handshake
//   or_in                             OR of magnitudes for the oldest unpaired block
//   or_in_valid / or_in_ready         OR-result handshake (pops the FIFO head)
//   data_out[IN_SIZE]                 normalised signed elements (OUT_WIDTH each)
//   exp_out                           shared exponent (right-shift amount)
//   data_out_valid / data_out_ready   output handshake
module mx_block_normalizer #(
  parameter int IN_SIZE   = 16,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int EXP_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_in,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  input  logic [IN_WIDTH-1:0]                  or_in,
  input  logic                                 or_in_valid,
  output logic                                 or_in_ready,
  output logic [IN_SIZE-1:0][OUT_WIDTH-1:0]    data_out,
  output logic [EXP_WIDTH-1:0]                 exp_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [IN_SIZE-1:0][IN_WIDTH-1:0] block_t;

  block_t                            mem [DEPTH];
  logic   [PW-1:0]                   rd_ptr;
  logic   [PW-1:0]                   wr_ptr;
  logic   [CW-1:0]                   count;
  logic                              push;
  logic                              pop;
  logic                              out_free;
  int                                lead_idx;
  logic   [EXP_WIDTH-1:0]            shift;
  logic   [IN_SIZE-1:0][OUT_WIDTH-1:0] data_norm;

  // Ready to the producer depends only on registered count, so output
  // backpressure never reaches data_in_ready combinationally.
  assign data_in_ready = (count < CW'(DEPTH));
  assign out_free      = !data_out_valid || data_out_ready;
  assign or_in_ready   = (count != '0) && out_free;
  assign push          = data_in_valid && data_in_ready;
  assign pop           = or_in_valid && or_in_ready;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Leading-one position of the OR result; an all-zero OR leaves lead at 0,
  // which yields shift 0 because OUT_WIDTH is at least 2.
  always_comb begin
    lead_idx = 0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (or_in[i]) lead_idx = i;
    end
    shift = '0;
    if (lead_idx + 2 > OUT_WIDTH) shift = EXP_WIDTH'(lead_idx + 2 - OUT_WIDTH);
  end

  // One sign bit plus OUT_WIDTH-1 magnitude bits survive the shift; the
  // truncation is safe because or_in bounds every element magnitude.
  for (genvar g = 0; g < IN_SIZE; g++) begin : g_norm
    assign data_norm[g] = OUT_WIDTH'($signed(mem[rd_ptr][g]) >>> shift);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      exp_out        <= '0;
      data_out_valid <= 1'b0;
    end else if (pop) begin
      data_out       <= data_norm;
      exp_out        <= shift;
      data_out_valid <= 1'b1;
    end else if (data_out_ready) begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mx_block_normalizer.sv
// tb/tb_mx_block_normalizer.sv - self-checking bench for mx_block_normalizer
module tb_mx_block_normalizer;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][15:0] data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [15:0]      or_in;
  logic             or_in_valid;
  logic             or_in_ready;
  logic [3:0][7:0]  data_out;
  logic [3:0]       exp_out;
  logic             data_out_valid;
  logic             data_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mx_block_normalizer #(
    .IN_SIZE(4), .IN_WIDTH(16), .OUT_WIDTH(8), .DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .or_in(or_in), .or_in_valid(or_in_valid), .or_in_ready(or_in_ready),
    .data_out(data_out), .exp_out(exp_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  typedef struct {
    logic [63:0] d;
    logic [15:0] o;
    logic [31:0] q;
    logic [3:0]  e;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [63:0] b16(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [31:0] b8(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [63:0] d);
    int n = 0;
    data_in = d;
    data_in_valid = 1'b1;
    while (!data_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", {63'd0, data_in_ready}, 64'd1);
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic send_or(input logic [15:0] v);
    int n = 0;
    or_in = v;
    or_in_valid = 1'b1;
    while (!or_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("or_timeout", {63'd0, or_in_ready}, 64'd1);
    @(negedge clk);
    or_in_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] q, input logic [3:0] e);
    check({name, "_valid"}, {63'd0, data_out_valid}, 64'd1);
    check({name, "_data"}, {32'd0, data_out}, {32'd0, q});
    check({name, "_exp"}, {60'd0, exp_out}, {60'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{d: b16(100, -50, 3, 0),       o: 16'h0077, q: b8(100, -50, 3, 0),   e: 4'd0};
    vecs[1] = '{d: b16(1000, -1000, 12, -1),  o: 16'h03ED, q: b8(125, -125, 1, -1), e: 4'd3};
    vecs[2] = '{d: b16(0, 0, 0, 0),           o: 16'h0000, q: b8(0, 0, 0, 0),       e: 4'd0};
    vecs[3] = '{d: b16(32767, -32768, 511, -1), o: 16'hFFFF, q: b8(63, -64, 0, -1), e: 4'd9};
    vecs[4] = '{d: b16(127, -127, 64, -1),    o: 16'h007F, q: b8(127, -127, 64, -1), e: 4'd0};
    vecs[5] = '{d: b16(128, -200, 5, -5),     o: 16'h00CD, q: b8(64, -100, 2, -3),  e: 4'd1};

    rst = 1'b1;
    data_in = '0; data_in_valid = 1'b0;
    or_in = '0; or_in_valid = 1'b0;
    data_out_ready = 1'b1;
    #12;
    check("rst_in_ready", {63'd0, data_in_ready}, 64'd1);
    check("rst_or_ready", {63'd0, or_in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, data_out_valid}, 64'd0);
    check("rst_data_out", {32'd0, data_out}, 64'd0);
    check("rst_exp_out", {60'd0, exp_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic normalisation vectors
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].d);
      send_or(vecs[i].o);
      check_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].e);
      @(negedge clk);
      check($sformatf("vec%0d_drop", i), {63'd0, data_out_valid}, 64'd0);
    end

    // Full FIFO: four pushes fill it, fifth is held until a pop
    push(b16(1, 2, 3, 4));
    push(b16(5, 6, 7, 8));
    push(b16(9, 10, 11, 12));
    push(b16(13, 14, 15, 16));
    check("full_ready_low", {63'd0, data_in_ready}, 64'd0);
    data_in = b16(17, 18, 19, 20);
    data_in_valid = 1'b1;
    @(negedge clk);
    check("full_held", {63'd0, data_in_ready}, 64'd0);
    or_in = 16'h007F;
    or_in_valid = 1'b1;
    @(negedge clk);
    or_in_valid = 1'b0;
    check("full_ready_back", {63'd0, data_in_ready}, 64'd1);
    check_out("full_blk0", b8(1, 2, 3, 4), 4'd0);
    @(negedge clk);
    data_in_valid = 1'b0;
    send_or(16'h007F);
    check_out("full_blk1", b8(5, 6, 7, 8), 4'd0);
    send_or(16'h007F);
    check_out("full_blk2", b8(9, 10, 11, 12), 4'd0);
    send_or(16'h007F);
    check_out("full_blk3", b8(13, 14, 15, 16), 4'd0);
    send_or(16'h007F);
    check_out("full_blk4", b8(17, 18, 19, 20), 4'd0);
    @(negedge clk);

    // or_in presented against an empty FIFO waits for a registered push
    or_in = 16'h007F;
    or_in_valid = 1'b1;
    @(negedge clk);
    check("empty_or_wait0", {63'd0, or_in_ready}, 64'd0);
    @(negedge clk);
    check("empty_or_wait1", {63'd0, or_in_ready}, 64'd0);
    data_in = b16(21, -22, 23, -24);
    data_in_valid = 1'b1;
    #1;
    check("empty_or_same_cycle", {63'd0, or_in_ready}, 64'd0);
    @(negedge clk);
    data_in_valid = 1'b0;
    check("empty_or_ready", {63'd0, or_in_ready}, 64'd1);
    @(negedge clk);
    or_in_valid = 1'b0;
    check_out("empty_blk", b8(21, -22, 23, -24), 4'd0);
    @(negedge clk);

    // Output backpressure with a second paired block waiting
    data_out_ready = 1'b0;
    push(b16(30, 31, 32, 33));
    push(b16(-40, 41, -42, 43));
    send_or(16'h007F);
    check_out("bp_first", b8(30, 31, 32, 33), 4'd0);
    or_in = 16'h007F;
    or_in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_or_blocked", {63'd0, or_in_ready}, 64'd0);
    check_out("bp_stable", b8(30, 31, 32, 33), 4'd0);
    data_out_ready = 1'b1;
    #1;
    check("bp_or_comb", {63'd0, or_in_ready}, 64'd1);
    @(negedge clk);
    or_in_valid = 1'b0;
    check_out("bp_second", b8(-40, 41, -42, 43), 4'd0);
    @(negedge clk);
    check("bp_drained", {63'd0, data_out_valid}, 64'd0);

    // Reset mid-operation discards buffered blocks and the pending beat
    data_out_ready = 1'b0;
    push(b16(50, 51, 52, 53));
    push(b16(54, 55, 56, 57));
    push(b16(58, 59, 60, 61));
    push(b16(62, 63, 64, 65));
    send_or(16'h007F);
    check_out("pre_rst", b8(50, 51, 52, 53), 4'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, data_out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, data_in_ready}, 64'd1);
    check("mid_rst_or_ready", {63'd0, or_in_ready}, 64'd0);
    check("mid_rst_data", {32'd0, data_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    data_out_ready = 1'b1;
    push(b16(70, -71, 72, -73));
    send_or(16'h007F);
    check_out("post_rst", b8(70, -71, 72, -73), 4'd0);
    @(negedge clk);
    check("post_rst_empty", {63'd0, or_in_ready}, 64'd0);
    check("post_rst_drop", {63'd0, data_out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
